// File: rtl/botao_alterna_led.sv
// Push-button front end: synchronizes and debounces the raw button on pino2.
// Each confirmed press toggles the LED on pino13, pulses once and bumps a counter.
module botao_alterna_led #(
  parameter int DEBOUNCE_CICLOS  = 4,
  parameter int LARGURA_CONTADOR = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pino2,
  output logic                        pino13,
  output logic                        pulso_pressao,
  output logic                        botao_estavel,
  output logic [LARGURA_CONTADOR-1:0] contagem_pressoes
);

  localparam int                          CW      = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0]               UM      = CW'(1'b1);
  localparam logic [CW-1:0]               ALVO    = CW'(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0]               ZERO    = {CW{1'b0}};
  localparam logic [LARGURA_CONTADOR-1:0] INC     = LARGURA_CONTADOR'(1'b1);
  localparam logic                        DIRETO  = (DEBOUNCE_CICLOS == 32'sd1);

  typedef enum logic [1:0] {
    SOLTO            = 2'd0,
    CONFIRMA_PRESSAO = 2'd1,
    PRESSIONADO      = 2'd2,
    CONFIRMA_SOLTURA = 2'd3
  } estado_t;

  logic                        r_s1;
  logic                        r_s2;
  estado_t                     r_estado;
  logic [CW-1:0]               r_cnt;
  logic                        r_led;
  logic                        r_pulso;
  logic [LARGURA_CONTADOR-1:0] r_contagem;

  estado_t       w_prox_estado;
  logic [CW-1:0] w_prox_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_pressao;

  assign w_cnt_inc = r_cnt + UM;

  // Debounce FSM: the candidate level must persist for DEBOUNCE_CICLOS samples of r_s2
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_cnt    = r_cnt;
    w_pressao     = 1'b0;
    case (r_estado)
      SOLTO: begin
        if (r_s2) begin
          if (DIRETO) begin
            w_prox_estado = PRESSIONADO;
            w_pressao     = 1'b1;
          end else begin
            w_prox_estado = CONFIRMA_PRESSAO;
            w_prox_cnt    = UM;
          end
        end else begin
          w_prox_estado = SOLTO;
        end
      end
      CONFIRMA_PRESSAO: begin
        if (!r_s2) begin
          w_prox_estado = SOLTO;
        end else if (w_cnt_inc == ALVO) begin
          w_prox_estado = PRESSIONADO;
          w_pressao     = 1'b1;
        end else begin
          w_prox_cnt = w_cnt_inc;
        end
      end
      PRESSIONADO: begin
        if (!r_s2) begin
          if (DIRETO) begin
            w_prox_estado = SOLTO;
          end else begin
            w_prox_estado = CONFIRMA_SOLTURA;
            w_prox_cnt    = UM;
          end
        end else begin
          w_prox_estado = PRESSIONADO;
        end
      end
      CONFIRMA_SOLTURA: begin
        if (r_s2) begin
          w_prox_estado = PRESSIONADO;
        end else if (w_cnt_inc == ALVO) begin
          w_prox_estado = SOLTO;
        end else begin
          w_prox_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_prox_estado = SOLTO;
        w_prox_cnt    = ZERO;
      end
    endcase
  end

  // Synchronizer, FSM state and registered press actions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_estado   <= SOLTO;
      r_cnt      <= ZERO;
      r_led      <= 1'b0;
      r_pulso    <= 1'b0;
      r_contagem <= {LARGURA_CONTADOR{1'b0}};
    end else begin
      r_s1     <= pino2;
      r_s2     <= r_s1;
      r_estado <= w_prox_estado;
      r_cnt    <= w_prox_cnt;
      r_pulso  <= w_pressao;
      if (w_pressao) begin
        r_led      <= ~r_led;
        r_contagem <= r_contagem + INC;
      end else begin
        r_led      <= r_led;
        r_contagem <= r_contagem;
      end
    end
  end

  assign pino13            = r_led;
  assign pulso_pressao     = r_pulso;
  assign contagem_pressoes = r_contagem;
  assign botao_estavel     = (r_estado == PRESSIONADO) || (r_estado == CONFIRMA_SOLTURA);

endmodule

// File: tb/tb_botao_alterna_led.sv
// Directed bench for botao_alterna_led with DEBOUNCE_CICLOS=4, 8-bit counter.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_botao_alterna_led;

  logic       clk;
  logic       rst;
  logic       pino2;
  logic       pino13;
  logic       pulso_pressao;
  logic       botao_estavel;
  logic [7:0] contagem_pressoes;

  int n_vec;
  int n_mis;
  int n_pulsos;
  int pulsos_antes;
  logic [4:0] padrao;

  botao_alterna_led #(
    .DEBOUNCE_CICLOS (4),
    .LARGURA_CONTADOR(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pino2            (pino2),
    .pino13           (pino13),
    .pulso_pressao    (pulso_pressao),
    .botao_estavel    (botao_estavel),
    .contagem_pressoes(contagem_pressoes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pulso_pressao === 1'b1) n_pulsos++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_mis    = 0;
    n_pulsos = 0;
    rst      = 1'b1;
    pino2    = 1'b1;

    // Reset held 2 cycles with the button pressed
    ticks(2);
    chk("rst_pino13", pino13, 0);
    chk("rst_pulso", pulso_pressao, 0);
    chk("rst_estavel", botao_estavel, 0);
    chk("rst_contagem", contagem_pressoes, 0);

    // First post-reset sample is e0; press lands after e0+5
    rst = 1'b0;
    ticks(5);
    chk("lat_pulso_cedo", pulso_pressao, 0);
    chk("lat_estavel_cedo", botao_estavel, 0);
    ticks(1);
    chk("p1_pulso", pulso_pressao, 1);
    chk("p1_pino13", pino13, 1);
    chk("p1_contagem", contagem_pressoes, 1);
    chk("p1_estavel", botao_estavel, 1);
    ticks(1);
    chk("p1_pulso_fim", pulso_pressao, 0);
    ticks(13);
    chk("p1_hold_contagem", contagem_pressoes, 1);
    chk("p1_hold_pulsos", n_pulsos, 1);

    // Release: botao_estavel falls 5 edges after e0
    pino2 = 1'b0;
    ticks(5);
    chk("rel1_estavel_cedo", botao_estavel, 1);
    ticks(1);
    chk("rel1_estavel", botao_estavel, 0);
    ticks(4);

    // Bounce 1,0,1,1,0 then steady 1
    padrao = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      pino2 = padrao[k];
      ticks(1);
      chk("bounce_sem_pulso", pulso_pressao, 0);
    end
    pino2 = 1'b1;
    ticks(5);
    chk("bounce_pulso_cedo", pulso_pressao, 0);
    ticks(1);
    chk("bounce_pulso", pulso_pressao, 1);
    chk("bounce_pino13", pino13, 0);
    chk("bounce_contagem", contagem_pressoes, 2);
    ticks(44);
    chk("hold_pulsos", n_pulsos, 2);
    chk("hold_estavel", botao_estavel, 1);

    // Two-cycle release glitch while pressed
    pino2 = 1'b0;
    ticks(2);
    pino2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ticks(1);
      chk("glitch_estavel", botao_estavel, 1);
      chk("glitch_pulso", pulso_pressao, 0);
    end
    chk("glitch_contagem", contagem_pressoes, 2);

    // Release 10 cycles then press again
    pino2 = 1'b0;
    ticks(10);
    chk("rel2_estavel", botao_estavel, 0);
    pino2 = 1'b1;
    ticks(6);
    chk("p3_pulso", pulso_pressao, 1);
    chk("p3_pino13", pino13, 1);
    chk("p3_contagem", contagem_pressoes, 3);
    pino2 = 1'b0;
    ticks(10);

    // 253 more presses wrap the counter to 0 after 256 in total
    pulsos_antes = n_pulsos;
    for (int k = 0; k < 253; k++) begin
      pino2 = 1'b1;
      ticks(7);
      pino2 = 1'b0;
      ticks(7);
    end
    chk("wrap_pulsos", n_pulsos - pulsos_antes, 253);
    chk("wrap_contagem", contagem_pressoes, 0);
    chk("wrap_pino13", pino13, 0);

    // One more press, then reset in the middle of CONFIRMA_PRESSAO
    pino2 = 1'b1;
    ticks(7);
    pino2 = 1'b0;
    ticks(7);
    chk("pre_mid_contagem", contagem_pressoes, 1);
    chk("pre_mid_pino13", pino13, 1);
    pulsos_antes = n_pulsos;
    pino2 = 1'b1;
    ticks(4);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    pino2 = 1'b0;
    chk("mid_pino13", pino13, 0);
    chk("mid_contagem", contagem_pressoes, 0);
    chk("mid_estavel", botao_estavel, 0);
    chk("mid_pulso", pulso_pressao, 0);
    ticks(8);
    chk("mid_sem_pulso", n_pulsos - pulsos_antes, 0);
    chk("mid_contagem_fim", contagem_pressoes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
